sonata_pinmux: RTL



---
 rtl/sonata_pinmux_pkg.sv | 19 +
 rtl/sonata_pinmux_in_filter.sv | 36 +++
 rtl/sonata_pinmux.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sonata_pinmux_pkg.sv
// Shared constants for the Sonata pin multiplexer: register map bases,
// select-field sizing and default geometry.
package sonata_pinmux_pkg;

    localparam int unsigned OutSelBase      = 32'h0000_0000;
    localparam int unsigned InSelBase       = 32'h0000_0200;
    localparam int unsigned FilterEnBit     = 31;

    localparam int unsigned DefNumPins      = 87;
    localparam int unsigned DefNumOutSrc    = 16;
    localparam int unsigned DefNumInSink    = 16;
    localparam int unsigned DefFilterCycles = 8;

    // A select field encodes "none" as 0 plus one code per choice.
    function automatic int unsigned sel_width(input int unsigned n_choices);
        return $clog2(n_choices + 1);
    endfunction

endpackage

// File: rtl/sonata_pinmux_in_filter.sv
// Per-sink glitch filter: the output only follows the input once the input
// has disagreed with it for FilterCycles consecutive samples.
module sonata_pinmux_in_filter #(
    parameter int unsigned FilterCycles = 8,
    parameter logic        IdleVal      = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    localparam int unsigned CntW = $clog2(FilterCycles);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= '0;
            q_o <= IdleVal;
        end else if (!en_i) begin
            cnt <= '0;
            q_o <= d_i;
        end else if (clr_i || (d_i == q_o)) begin
            cnt <= '0;
        end else if (cnt == CntW'(FilterCycles - 1)) begin
            cnt <= '0;
            q_o <= d_i;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sonata_pinmux.sv
// Register-programmable pin multiplexer between the peripheral cluster and
// the board pins, with synchronised and optionally filtered input sinks.
module sonata_pinmux
    import sonata_pinmux_pkg::*;
#(
    parameter int unsigned          NumPins      = DefNumPins,
    parameter int unsigned          NumOutSrc    = DefNumOutSrc,
    parameter int unsigned          NumInSink    = DefNumInSink,
    parameter int unsigned          FilterCycles = DefFilterCycles,
    parameter logic [NumInSink-1:0] InIdle       = '1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 reg_req_i,
    input  logic                 reg_we_i,
    input  logic [9:0]           reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_rvalid_o,
    input  logic [NumOutSrc-1:0] periph_out_i,
    input  logic [NumOutSrc-1:0] periph_oe_i,
    output logic [NumPins-1:0]   pin_out_o,
    output logic [NumPins-1:0]   pin_oe_o,
    input  logic [NumPins-1:0]   pin_in_i,
    output logic [NumInSink-1:0] periph_in_o
);

    localparam int unsigned OutSelW = sel_width(NumOutSrc);
    localparam int unsigned InSelW  = sel_width(NumPins);

    logic [OutSelW-1:0]   outsel [NumPins];
    logic [InSelW-1:0]    insel  [NumInSink];
    logic [NumInSink-1:0] insel_fen;
    logic [NumInSink-1:0] insel_wr;

    logic [31:0]          addr_ext;
    logic                 wr_en;
    logic                 rd_en;
    logic [OutSelW-1:0]   wr_outsel;
    logic [InSelW-1:0]    wr_insel;
    logic [31:0]          rd_val;
    logic                 unused_wdata;

    logic [NumPins-1:0]   pin_sync_p0;
    logic [NumPins-1:0]   pin_sync_p1;
    logic [NumPins-1:0]   pin_out_nxt;
    logic [NumPins-1:0]   pin_oe_nxt;
    logic [NumInSink-1:0] sink_mux;

    assign addr_ext     = {22'd0, reg_addr_i};
    assign wr_en        = reg_req_i & reg_we_i;
    assign rd_en        = reg_req_i & ~reg_we_i;
    assign unused_wdata = ^reg_wdata_i;

    // Out-of-range selections collapse to "disabled" rather than aliasing.
    assign wr_outsel = (reg_wdata_i[OutSelW-1:0] > OutSelW'(NumOutSrc)) ? '0
                                                                        : reg_wdata_i[OutSelW-1:0];
    assign wr_insel  = (reg_wdata_i[InSelW-1:0] > InSelW'(NumPins)) ? '0
                                                                    : reg_wdata_i[InSelW-1:0];

    always_comb begin
        rd_val   = '0;
        insel_wr = '0;
        for (int p = 0; p < NumPins; p++) begin
            if (addr_ext == 32'(OutSelBase) + 32'(p)) rd_val = 32'(outsel[p]);
        end
        for (int s = 0; s < NumInSink; s++) begin
            if (addr_ext == 32'(InSelBase) + 32'(s)) begin
                rd_val              = 32'(insel[s]);
                rd_val[FilterEnBit] = insel_fen[s];
                insel_wr[s]         = wr_en;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumPins; p++) outsel[p] <= '0;
            for (int s = 0; s < NumInSink; s++) insel[s] <= '0;
            insel_fen    <= '0;
            reg_rvalid_o <= 1'b0;
            reg_rdata_o  <= '0;
        end else begin
            for (int p = 0; p < NumPins; p++) begin
                if (wr_en && (addr_ext == 32'(OutSelBase) + 32'(p))) outsel[p] <= wr_outsel;
            end
            for (int s = 0; s < NumInSink; s++) begin
                if (insel_wr[s]) begin
                    insel[s]     <= wr_insel;
                    insel_fen[s] <= reg_wdata_i[FilterEnBit];
                end
            end
            reg_rvalid_o <= reg_req_i;
            reg_rdata_o  <= rd_en ? rd_val : '0;
        end
    end

    always_comb begin
        pin_out_nxt = '0;
        pin_oe_nxt  = '0;
        for (int p = 0; p < NumPins; p++) begin
            for (int k = 0; k < NumOutSrc; k++) begin
                if (outsel[p] == OutSelW'(k + 1)) begin
                    pin_out_nxt[p] = periph_out_i[k];
                    pin_oe_nxt[p]  = periph_oe_i[k];
                end
            end
        end
    end

    // Output stage: one register between the source mux and the pads.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pin_out_o <= '0;
            pin_oe_o  <= '0;
        end else begin
            pin_out_o <= pin_out_nxt;
            pin_oe_o  <= pin_oe_nxt;
        end
    end

    // Input stage: two-flop synchroniser ahead of the sink mux.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pin_sync_p0 <= '1;
            pin_sync_p1 <= '1;
        end else begin
            pin_sync_p0 <= pin_in_i;
            pin_sync_p1 <= pin_sync_p0;
        end
    end

    always_comb begin
        sink_mux = InIdle;
        for (int s = 0; s < NumInSink; s++) begin
            for (int q = 0; q < NumPins; q++) begin
                if (insel[s] == InSelW'(q + 1)) sink_mux[s] = pin_sync_p1[q];
            end
        end
    end

    for (genvar s = 0; s < NumInSink; s++) begin : g_sink
        sonata_pinmux_in_filter #(
            .FilterCycles (FilterCycles),
            .IdleVal      (InIdle[s])
        ) u_filter (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en_i   (insel_fen[s]),
            .clr_i  (insel_wr[s]),
            .d_i    (sink_mux[s]),
            .q_o    (periph_in_o[s])
        );
    end

endmodule
